// File: rtl/qos_vc_switch.sv
`default_nettype none
// ============================================================================
// Module   : qos_vc_switch
// Summary  : N_CH-class QoS switch. Ingress words are sorted into class FIFOs
//            by their top CH_W bits. A round-robin / strict-priority arbiter
//            moves at most one word per cycle into the matching egress FIFO.
//            The design also has a RESET/INIT/IDLE/ACTIVE control FSM,
//            programmable thresholds and saturating statistics counters.
// Options  : QOS_DROP_CNT_EN - include the overflow drop counter (idx = N_CH)
// Revision : 1.0 - initial release
// ============================================================================
module qos_vc_switch #(
  parameter int DATA_W = 12,
  parameter int N_CH   = 4,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   init,
  input  logic [$clog2(DEPTH):0] umbral_high,
  input  logic [$clog2(DEPTH):0] umbral_low,
  input  logic                   prio_mode,
  input  logic                   push,
  input  logic [DATA_W-1:0]      data_in,
  input  logic [N_CH-1:0]        pop,
  output logic [N_CH*DATA_W-1:0] fifo_dataout,
  output logic [N_CH-1:0]        egress_empty,
  output logic [N_CH-1:0]        egress_almost_empty,
  input  logic                   req,
  input  logic [$clog2(N_CH):0]  idx,
  output logic                   valid,
  output logic [CNT_W-1:0]       data,
  output logic                   active_out,
  output logic                   idle_out
);

  localparam int               CH_W    = $clog2(N_CH);
  localparam int               AW      = $clog2(DEPTH);
  localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t           state_q;
  logic [AW:0]      high_q;
  logic [AW:0]      low_q;
  logic [CH_W-1:0]  rr_q;
  logic             valid_q;
  logic [CNT_W-1:0] data_q;

  logic [CH_W-1:0]              w_cls_sel;
  logic [N_CH-1:0]              w_cls_ne;
  logic [N_CH-1:0]              w_cls_full;
  logic [N_CH-1:0]              w_elig;
  logic [N_CH-1:0]              w_cls_wr;
  logic [N_CH-1:0]              w_cls_rd;
  logic                         w_gnt_vld;
  logic [CH_W-1:0]              w_gnt_idx;
  logic                         w_push_ok;
  logic [N_CH-1:0][CNT_W-1:0]   w_cnt_all;
  logic [CNT_W-1:0]             w_stat;

  assign w_cls_sel  = data_in[DATA_W-1 -: CH_W];
  assign active_out = (state_q == ST_ACTIVE);
  assign idle_out   = (state_q == ST_IDLE);
  assign valid      = valid_q;
  assign data       = data_q;

  // Arbiter: strict priority takes the highest eligible index, round-robin the
  // first eligible index after rr_q (descending scan so the nearest one wins).
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (state_q == ST_ACTIVE) begin
      if (prio_mode) begin
        for (int i = 0; i < N_CH; i++) begin
          if (w_elig[i]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = CH_W'(i);
          end
        end
      end else begin
        for (int k = N_CH; k >= 1; k--) begin
          if (w_elig[rr_q + CH_W'(k)]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = rr_q + CH_W'(k);
          end
        end
      end
    end
  end

  // Ingress accept: a full class still takes a push when it is granted this cycle.
  always_comb begin
    w_cls_rd  = '0;
    w_cls_wr  = '0;
    w_push_ok = 1'b0;
    if (w_gnt_vld) w_cls_rd[w_gnt_idx] = 1'b1;
    if (push && (state_q != ST_RESET))
      w_push_ok = !w_cls_full[w_cls_sel] || w_cls_rd[w_cls_sel];
    w_cls_wr[w_cls_sel] = w_push_ok;
  end

`ifdef QOS_DROP_CNT_EN
  logic [CNT_W-1:0] drop_q;
  logic             w_drop;
  assign w_drop = push && (state_q != ST_RESET) && !w_push_ok;

  // Saturating count of pushes rejected because the class FIFO was full
  always_ff @(posedge clk) begin
    if (!reset)                         drop_q <= '0;
    else if (w_drop && drop_q != CNT_MAX) drop_q <= drop_q + CNT_W'(1);
  end
`endif

  // Statistics select: per-channel pop counters, then drop counter, then zero
  always_comb begin
    w_stat = '0;
    if (idx < (CH_W+1)'(N_CH))
      w_stat = w_cnt_all[idx[CH_W-1:0]];
`ifdef QOS_DROP_CNT_EN
    else if (idx == (CH_W+1)'(N_CH))
      w_stat = drop_q;
`endif
  end

  // Control FSM, threshold latches, RR pointer and statistics read port
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RESET;
      high_q  <= DEPTH_C - (AW+1)'(1);
      low_q   <= (AW+1)'(1);
      rr_q    <= CH_W'(N_CH - 1);
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (w_gnt_vld && !prio_mode) rr_q <= w_gnt_idx;
      if (req && (state_q == ST_IDLE)) begin
        valid_q <= 1'b1;
        data_q  <= w_stat;
      end else begin
        valid_q <= 1'b0;
      end
      case (state_q)
        ST_RESET: state_q <= ST_INIT;
        ST_INIT: begin
          high_q <= (umbral_high == '0) ? DEPTH_C : umbral_high;
          low_q  <= (umbral_low  == '0) ? DEPTH_C : umbral_low;
          if (!init) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (init)           state_q <= ST_INIT;
          else if (|w_cls_ne) state_q <= ST_ACTIVE;
        end
        default: begin
          if (init)            state_q <= ST_INIT;
          else if (!(|w_cls_ne)) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [DEPTH-1:0][DATA_W-1:0] cls_mem_q;
    logic [DEPTH-1:0][DATA_W-1:0] egr_mem_q;
    logic [AW-1:0]                cls_wr_q, cls_rd_q, egr_wr_q, egr_rd_q;
    logic [AW:0]                  cls_cnt_q, egr_cnt_q;
    logic [CNT_W-1:0]             pop_cnt_q;
    logic                         w_egr_rd;

    assign w_egr_rd                       = pop[g] && (egr_cnt_q != '0);
    assign w_cls_ne[g]                    = (cls_cnt_q != '0);
    assign w_cls_full[g]                  = (cls_cnt_q == DEPTH_C);
    assign w_elig[g]                      = w_cls_ne[g] && (egr_cnt_q < high_q);
    assign w_cnt_all[g]                   = pop_cnt_q;
    assign fifo_dataout[g*DATA_W +: DATA_W] = egr_mem_q[egr_rd_q];
    assign egress_empty[g]                = (egr_cnt_q == '0);
    assign egress_almost_empty[g]         = (egr_cnt_q <= low_q);

    // Class FIFO: written by ingress, read by the arbiter grant
    always_ff @(posedge clk) begin
      if (!reset) begin
        cls_mem_q <= '0;
        cls_wr_q  <= '0;
        cls_rd_q  <= '0;
        cls_cnt_q <= '0;
      end else begin
        if (w_cls_wr[g]) begin
          cls_mem_q[cls_wr_q] <= data_in;
          cls_wr_q            <= cls_wr_q + AW'(1);
        end
        if (w_cls_rd[g]) cls_rd_q <= cls_rd_q + AW'(1);
        case ({w_cls_wr[g], w_cls_rd[g]})
          2'b10:   cls_cnt_q <= cls_cnt_q + (AW+1)'(1);
          2'b01:   cls_cnt_q <= cls_cnt_q - (AW+1)'(1);
          default: ;
        endcase
      end
    end

    // Egress FIFO (show-ahead head) plus its saturating pop counter
    always_ff @(posedge clk) begin
      if (!reset) begin
        egr_mem_q <= '0;
        egr_wr_q  <= '0;
        egr_rd_q  <= '0;
        egr_cnt_q <= '0;
        pop_cnt_q <= '0;
      end else begin
        if (w_cls_rd[g]) begin
          egr_mem_q[egr_wr_q] <= cls_mem_q[cls_rd_q];
          egr_wr_q            <= egr_wr_q + AW'(1);
        end
        if (w_egr_rd) begin
          egr_rd_q <= egr_rd_q + AW'(1);
          if (pop_cnt_q != CNT_MAX) pop_cnt_q <= pop_cnt_q + CNT_W'(1);
        end
        case ({w_cls_rd[g], w_egr_rd})
          2'b10:   egr_cnt_q <= egr_cnt_q + (AW+1)'(1);
          2'b01:   egr_cnt_q <= egr_cnt_q - (AW+1)'(1);
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
